// File: rtl/axi_tx.sv
// ============================================================================
//  Module      : axi_tx
//  Description : Transmit side of the ASIC serial link. Accepts words over a
//                valid/ready handshake into a one-entry buffer and shifts
//                them MSB-first onto sclk/sdata/svalid. sclk is divided down
//                from aclk, so the whole block is one clock domain.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module axi_tx #(
  parameter int PACKET_LENGTH = 32,
  parameter int CLK_DIV       = 2,
  parameter int IDLE_GAP      = 0
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [PACKET_LENGTH-1:0] s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic                     sclk,
  output logic                     sdata,
  output logic                     svalid,
  output logic                     tx_busy,
  output logic                     tx_done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(PACKET_LENGTH);
  localparam int GAP_W = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                   state, state_n;
  logic [DIV_W-1:0]         div_cnt;
  logic                     div_wrap;
  logic                     rise_tick;
  logic [PACKET_LENGTH-1:0] buf_data;
  logic                     buf_full;
  logic                     take;
  logic                     do_load;
  logic [PACKET_LENGTH-1:0] shreg, shreg_n;
  logic [CNT_W-1:0]         bit_cnt, bit_n;
  logic [GAP_W-1:0]         gap_cnt, gap_n;
  logic                     sdata_n, svalid_n, done_n;

  assign div_wrap  = (div_cnt == DIV_W'(CLK_DIV - 1));
  // sclk is about to go 0->1 at the end of this aclk cycle
  assign rise_tick = div_wrap && !sclk;
  assign s_ready   = !buf_full;
  assign take      = s_valid && s_ready;
  assign tx_busy   = (state != IDLE) || buf_full;

  // Free-running sclk divider: toggle every CLK_DIV aclk cycles
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // One-entry holding buffer; a load into the shift register frees it unless
  // a new word is accepted in the same cycle
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      buf_full <= 1'b0;
      buf_data <= '0;
    end else begin
      if (take) begin
        buf_data <= s_data;
      end
      if (take) begin
        buf_full <= 1'b1;
      end else if (do_load) begin
        buf_full <= 1'b0;
      end
    end
  end

  // FSM and serial datapath registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      sdata   <= 1'b0;
      svalid  <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_cnt <= bit_n;
      gap_cnt <= gap_n;
      sdata   <= sdata_n;
      svalid  <= svalid_n;
      tx_done <= done_n;
    end
  end

  // Next-state logic; every serial output change is gated by rise_tick
  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    bit_n    = bit_cnt;
    gap_n    = gap_cnt;
    sdata_n  = sdata;
    svalid_n = svalid;
    done_n   = 1'b0;
    do_load  = 1'b0;

    case (state)
      IDLE: begin
        if (rise_tick && buf_full) begin
          do_load = 1'b1;
        end
      end
      SHIFT: begin
        if (rise_tick) begin
          if (bit_cnt == CNT_W'(PACKET_LENGTH - 1)) begin
            done_n = 1'b1;
            if ((IDLE_GAP == 0) && buf_full) begin
              do_load = 1'b1;
            end else begin
              svalid_n = 1'b0;
              sdata_n  = 1'b0;
              if (IDLE_GAP == 0) begin
                state_n = IDLE;
              end else begin
                state_n = GAP;
                gap_n   = GAP_W'(IDLE_GAP);
              end
            end
          end else begin
            shreg_n = shreg << 1;
            sdata_n = shreg[PACKET_LENGTH-2];
            bit_n   = bit_cnt + 1'b1;
          end
        end
      end
      GAP: begin
        if (rise_tick) begin
          if (gap_cnt <= GAP_W'(1)) begin
            gap_n   = '0;
            state_n = IDLE;
          end else begin
            gap_n = gap_cnt - 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Loading a word overrides whatever the case arm chose for the datapath
    if (do_load) begin
      shreg_n  = buf_data;
      sdata_n  = buf_data[PACKET_LENGTH-1];
      svalid_n = 1'b1;
      bit_n    = '0;
      state_n  = SHIFT;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_tx.sv
// ============================================================================
//  Module      : tb_axi_tx
//  Description : Directed self-checking bench for axi_tx. Three instances
//                (32b/div2/no gap, 32b/div2/gap3, 8b/div1/no gap) share one
//                clock and reset; a loopback receiver samples each link on
//                sclk falling edges.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi_tx;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [31:0] a_data, b_data;
  logic [7:0]  c_data;
  logic a_valid, b_valid, c_valid;
  logic a_ready, a_sclk, a_sdata, a_svalid, a_busy, a_done;
  logic b_ready, b_sclk, b_sdata, b_svalid, b_busy, b_done;
  logic c_ready, c_sclk, c_sdata, c_svalid, c_busy, c_done;

  axi_tx #(.PACKET_LENGTH(32), .CLK_DIV(2), .IDLE_GAP(0)) u_a (
    .aclk(aclk), .aresetn(aresetn), .s_data(a_data), .s_valid(a_valid),
    .s_ready(a_ready), .sclk(a_sclk), .sdata(a_sdata), .svalid(a_svalid),
    .tx_busy(a_busy), .tx_done(a_done));

  axi_tx #(.PACKET_LENGTH(32), .CLK_DIV(2), .IDLE_GAP(3)) u_b (
    .aclk(aclk), .aresetn(aresetn), .s_data(b_data), .s_valid(b_valid),
    .s_ready(b_ready), .sclk(b_sclk), .sdata(b_sdata), .svalid(b_svalid),
    .tx_busy(b_busy), .tx_done(b_done));

  axi_tx #(.PACKET_LENGTH(8), .CLK_DIV(1), .IDLE_GAP(0)) u_c (
    .aclk(aclk), .aresetn(aresetn), .s_data(c_data), .s_valid(c_valid),
    .s_ready(c_ready), .sclk(c_sclk), .sdata(c_sdata), .svalid(c_svalid),
    .tx_busy(c_busy), .tx_done(c_done));

  logic [2:0] m_sclk, m_sdata, m_svalid, m_done;
  assign m_sclk   = {c_sclk,   b_sclk,   a_sclk};
  assign m_sdata  = {c_sdata,  b_sdata,  a_sdata};
  assign m_svalid = {c_svalid, b_svalid, a_svalid};
  assign m_done   = {c_done,   b_done,   a_done};

  int n_vec = 0;
  int n_err = 0;

  function automatic int plen(input int i);
    return (i == 2) ? 8 : 32;
  endfunction

  function automatic logic [31:0] mask(input int i);
    return (plen(i) == 32) ? 32'hFFFF_FFFF : ((32'd1 << plen(i)) - 32'd1);
  endfunction

  // Loopback receiver and link statistics, sampled on aclk falling edges
  logic        clr_stats = 1'b1;
  int          cyc = 0;
  logic [31:0] rx_sr   [3];
  logic [31:0] rx_word [3][8];
  int          rx_bits [3];
  int          rx_cnt  [3];
  int          hi_run  [3];
  int          lo_run  [3];
  int          last_hi [3];
  int          last_lo [3];
  int          dcnt    [3];
  int          dtime   [3][4];
  logic        prev_sc [3];
  logic        seen_hi [3];

  always @(negedge aclk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (clr_stats) begin
        rx_sr[i] = '0; rx_bits[i] = 0; rx_cnt[i] = 0;
        hi_run[i] = 0; lo_run[i] = 0; last_hi[i] = 0; last_lo[i] = 0;
        dcnt[i] = 0; seen_hi[i] = 1'b0; prev_sc[i] = m_sclk[i];
      end else if (!aresetn) begin
        rx_bits[i] = 0; hi_run[i] = 0; prev_sc[i] = 1'b0;
      end else begin
        if (prev_sc[i] && !m_sclk[i] && m_svalid[i]) begin
          rx_sr[i] = {rx_sr[i][30:0], m_sdata[i]};
          rx_bits[i]++;
          if (rx_bits[i] == plen(i)) begin
            if (rx_cnt[i] < 8) rx_word[i][rx_cnt[i]] = rx_sr[i] & mask(i);
            rx_cnt[i]++;
            rx_bits[i] = 0;
          end
        end
        prev_sc[i] = m_sclk[i];
        if (m_svalid[i]) begin
          if (seen_hi[i] && lo_run[i] > 0) last_lo[i] = lo_run[i];
          lo_run[i] = 0;
          hi_run[i]++;
          seen_hi[i] = 1'b1;
        end else begin
          if (hi_run[i] > 0) last_hi[i] = hi_run[i];
          hi_run[i] = 0;
          lo_run[i]++;
        end
        if (m_done[i]) begin
          if (dcnt[i] < 4) dtime[i][dcnt[i]] = cyc;
          dcnt[i]++;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ready_of(input int which);
    return (which == 0) ? a_ready : (which == 1) ? b_ready : c_ready;
  endfunction

  function automatic logic busy_of(input int which);
    return (which == 0) ? a_busy : (which == 1) ? b_busy : c_busy;
  endfunction

  task automatic clear_stats();
    clr_stats = 1'b1;
    @(negedge aclk);
    #1 clr_stats = 1'b0;
  endtask

  // Present a word and return just after the accepting clock edge
  task automatic send(input int which, input logic [31:0] w);
    int t;
    @(negedge aclk);
    case (which)
      0:       begin a_data = w;      a_valid = 1'b1; end
      1:       begin b_data = w;      b_valid = 1'b1; end
      default: begin c_data = w[7:0]; c_valid = 1'b1; end
    endcase
    t = 0;
    while (!ready_of(which) && t < 2000) begin
      @(negedge aclk);
      t++;
    end
    check("send_ready", {31'd0, ready_of(which)}, 32'd1);
    @(posedge aclk);
  endtask

  task automatic idle_in();
    @(negedge aclk);
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
  endtask

  task automatic wait_idle(input int which, input int limit, input string tag);
    int t;
    t = 0;
    while (busy_of(which) && t < limit) begin
      @(negedge aclk);
      t++;
    end
    check(tag, {31'd0, busy_of(which)}, 32'd0);
    repeat (8) @(negedge aclk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic prev;
    int   tg;
    int   t;
    a_data = '0; b_data = '0; c_data = '0;
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;

    // Reset state
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    check("rst_sclk",   {31'd0, a_sclk},   32'd0);
    check("rst_sdata",  {31'd0, a_sdata},  32'd0);
    check("rst_svalid", {31'd0, a_svalid}, 32'd0);
    check("rst_ready",  {31'd0, a_ready},  32'd1);
    check("rst_busy",   {31'd0, a_busy},   32'd0);
    check("rst_done",   {31'd0, a_done},   32'd0);
    check("rst_c_ready", {31'd0, c_ready}, 32'd1);
    aresetn = 1'b1;
    clear_stats();

    // sclk period: 4 aclk for div 2, 2 aclk for div 1
    tg = 0; prev = a_sclk;
    repeat (8) begin @(negedge aclk); if (a_sclk != prev) tg++; prev = a_sclk; end
    check("a_sclk_toggles", tg, 32'd4);
    tg = 0; prev = c_sclk;
    repeat (4) begin @(negedge aclk); if (c_sclk != prev) tg++; prev = c_sclk; end
    check("c_sclk_toggles", tg, 32'd4);

    // Single word
    clear_stats();
    send(0, 32'hA5A5_F00F);
    idle_in();
    wait_idle(0, 1000, "single_idle");
    check("single_cnt",  rx_cnt[0],     32'd1);
    check("single_word", rx_word[0][0], 32'hA5A5_F00F);
    check("single_hi",   last_hi[0],    32'd128);
    check("single_done", dcnt[0],       32'd1);

    // Back-to-back, no gap
    clear_stats();
    send(0, 32'h0000_0001);
    send(0, 32'h8000_0000);
    idle_in();
    wait_idle(0, 2000, "b2b_idle");
    check("b2b_cnt",   rx_cnt[0],     32'd2);
    check("b2b_word0", rx_word[0][0], 32'h0000_0001);
    check("b2b_word1", rx_word[0][1], 32'h8000_0000);
    check("b2b_hi",    last_hi[0],    32'd256);
    check("b2b_done",  dcnt[0],       32'd2);
    check("b2b_space", dtime[0][1] - dtime[0][0], 32'd128);

    // Gap insertion
    clear_stats();
    send(1, 32'hCAFE_0123);
    send(1, 32'h7654_FEDC);
    idle_in();
    wait_idle(1, 2000, "gap_idle");
    check("gap_cnt",   rx_cnt[1],     32'd2);
    check("gap_word0", rx_word[1][0], 32'hCAFE_0123);
    check("gap_word1", rx_word[1][1], 32'h7654_FEDC);
    check("gap_len",   {31'd0, last_lo[1] >= 12}, 32'd1);
    check("gap_done",  dcnt[1],       32'd2);

    // Backpressure with three words held valid
    clear_stats();
    send(0, 32'h1111_1111);
    @(negedge aclk);
    check("bp_ready_full", {31'd0, a_ready}, 32'd0);
    send(0, 32'h2222_2222);
    repeat (20) @(negedge aclk);
    check("bp_ready_hold", {31'd0, a_ready}, 32'd0);
    check("bp_busy",       {31'd0, a_busy},  32'd1);
    send(0, 32'h3333_3333);
    idle_in();
    wait_idle(0, 2000, "bp_idle");
    check("bp_cnt",   rx_cnt[0],     32'd3);
    check("bp_word0", rx_word[0][0], 32'h1111_1111);
    check("bp_word1", rx_word[0][1], 32'h2222_2222);
    check("bp_word2", rx_word[0][2], 32'h3333_3333);
    check("bp_done",  dcnt[0],       32'd3);

    // Reset mid-packet
    clear_stats();
    send(0, 32'hDEAD_BEEF);
    idle_in();
    t = 0;
    while (rx_bits[0] < 11 && t < 2000) begin
      @(negedge aclk);
      t++;
    end
    check("mid_bits_reached", {31'd0, rx_bits[0] >= 11}, 32'd1);
    #2 aresetn = 1'b0;
    #1;
    check("mid_sclk",   {31'd0, a_sclk},   32'd0);
    check("mid_sdata",  {31'd0, a_sdata},  32'd0);
    check("mid_svalid", {31'd0, a_svalid}, 32'd0);
    check("mid_ready",  {31'd0, a_ready},  32'd1);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    clear_stats();
    send(0, 32'h1234_5678);
    idle_in();
    wait_idle(0, 1000, "mid_idle");
    check("mid_cnt",  rx_cnt[0],     32'd1);
    check("mid_word", rx_word[0][0], 32'h1234_5678);

    // 8-bit packet at divide-by-1
    clear_stats();
    send(2, 32'h0000_00C3);
    idle_in();
    wait_idle(2, 500, "c_idle");
    check("c_cnt",  rx_cnt[2],     32'd1);
    check("c_word", rx_word[2][0], 32'h0000_00C3);
    check("c_hi",   last_hi[2],    32'd16);
    check("c_done", dcnt[2],       32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
